paralelo_serial_tx: RTL
=======================

Name: paralelo_serial_tx

Overview:
- Transmit-side serializer that feeds the lane directly upstream of the serial-to-parallel receiver.
- Accepts bytes over a valid/ready handshake and shifts each byte out MSB-first, one bit per clock32 cycle.
- Fills every idle symbol slot with the COM symbol 0xBC so the receiver can keep byte alignment.
- After reset, emits a fixed preamble of COM symbols before it accepts any data.

Parameters:
- COM_SYM, 8'hBC, idle/alignment symbol inserted when no data is pending.
- INIT_COM, 4, number of COM symbols sent after reset before ready_out may assert (range 1..15).
- MAX_RUN, 64, maximum consecutive data symbols before a forced COM; used only with SKIP_INSERT_EN (range 1..255).

Ports:
- clock32  input  1  bit clock; one serial bit per rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to transmit.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block can accept a byte this cycle.
- data_out  output  1  serial line, MSB of each symbol first.
- sym_start  output  1  high in the cycle data_out carries bit 7 of a symbol.
- active_out  output  1  high for all 8 bits of a data symbol; low during COM symbols.

Behaviour:
- One clock domain: clock32. Reset is asynchronous and active-high.
- Reset values:
  - shift register = COM_SYM, bit_cnt = 0, com_cnt = 0, hold_valid = 0, state = INIT.
  - Outputs during reset: data_out = 1 (shift[7] of 0xBC), sym_start = 1, active_out = 0, ready_out = 0.
- data_out = shift[7] (combinational from the register). sym_start = (bit_cnt == 0).
- Each cycle the register shifts left by one. bit_cnt counts 0..7 and wraps.
- Symbol boundary: the edge where bit_cnt == 7. On that edge the next symbol loads:
  - In INIT: load COM_SYM and increment com_cnt. When com_cnt reaches INIT_COM-1, go to RUN on the same edge.
  - In RUN with hold_valid = 1: load hold, clear hold_valid, set active_out = 1 for the next symbol.
  - In RUN with hold_valid = 0: load COM_SYM and set active_out = 0.
- Holding register: a single byte.
  - ready_out = (state == RUN) && !hold_valid.
  - A byte is accepted when valid_in && ready_out: hold <= data_in, hold_valid <= 1.
  - Same cycle as a boundary load: hold empties and ready_out stays low that cycle. ready_out rises the next cycle, so there is no simultaneous load and accept.
- Latency: a byte accepted in cycle t appears with sym_start at the first boundary after t, i.e. 1..8 cycles later.
- Sustained throughput: one byte per 8 cycles. Upstream must present the next byte within 7 cycles of ready_out rising to avoid a COM gap.
- Data equal to COM_SYM is transmitted verbatim. The receiver drops it; avoiding it is the upstream's responsibility.
- valid_in while ready_out = 0: ignored, not stored. Upstream holds the byte.
- Reset asserted mid-symbol: the partial symbol is abandoned immediately, any held byte is lost, and the INIT preamble restarts.

Optional Feature:
- Macro: SKIP_INSERT_EN.
- When defined:
  - An 8-bit run counter counts consecutive data symbols.
  - When it reaches MAX_RUN, the next boundary loads COM_SYM even if hold_valid = 1. hold is kept and the counter clears.
  - Any COM symbol also clears the counter.
- When undefined: no run counter. Data may stream indefinitely with no COM between bytes.

Decomposition:
- Shared package/header: COM_SYM, state encodings (INIT, RUN), symbol width 8.
- Optional sub-module tx_shift8: shift register plus bit_cnt and the boundary strobe. The top level keeps the FSM, hold register and feature logic.

Test Plan:
- Reset release, valid_in = 0 for 64 cycles -> 8 back-to-back 0xBC patterns (1,0,1,1,1,1,0,0); ready_out = 0 for the first 32 cycles, then 1; active_out = 0 throughout.
- After INIT, present 0x5A at a boundary-2 cycle -> ready_out drops the next cycle; at the next boundary data_out = 0,1,0,1,1,0,1,0 with active_out = 1; then 0xBC resumes.
- Stream 0x01..0x10, presenting each byte immediately on ready_out -> 16 contiguous data symbols with no COM between; sym_start every 8 cycles.
- valid_in held high while ready_out = 0 with a changing data_in -> only the value present on the accept cycle is transmitted.
- Assert reset at bit 3 of data symbol 0xA5 -> outputs take reset values asynchronously; after release a full INIT preamble runs, and 0xA5 is never completed.
- With SKIP_INSERT_EN and MAX_RUN = 4, stream 10 bytes -> pattern D,D,D,D,COM,D,D,D,D,COM,D,D with no byte lost or reordered.

Source files
------------

// File: rtl/paralelo_serial_tx_pkg.sv
// Shared definitions for the paralelo_serial_tx serializer: symbol width,
// default alignment symbol and FSM state encoding.
package paralelo_serial_tx_pkg;

    localparam int                SYM_W       = 8;
    localparam int                BIT_CNT_W   = $clog2(SYM_W);
    localparam logic [SYM_W-1:0]  COM_SYM_DEF = 8'hBC;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx_shift8.sv
// Symbol shifter: MSB-first shift register with bit counter; a new symbol
// is loaded on the boundary edge (last bit of the current symbol).
module paralelo_serial_tx_shift8
    import paralelo_serial_tx_pkg::*;
#(
    parameter logic [SYM_W-1:0] RST_SYM = COM_SYM_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SYM_W-1:0] load_sym_i,
    output logic             msb_o,
    output logic             sym_start_o,
    output logic             boundary_o
);

    logic [SYM_W-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign msb_o       = shift_q[SYM_W-1];
    assign sym_start_o = (bit_cnt_q == '0);
    assign boundary_o  = (bit_cnt_q == BIT_CNT_W'(SYM_W - 1));

    always_comb begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        shift_d   = boundary_o ? load_sym_i : {shift_q[SYM_W-2:0], 1'b0};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q   <= RST_SYM;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter with COM idle fill and a COM preamble after reset.
// Optional macro SKIP_INSERT_EN forces a COM after MAX_RUN consecutive data symbols.
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter logic [SYM_W-1:0] COM_SYM  = COM_SYM_DEF,
    parameter int               INIT_COM = 4,
    parameter int               MAX_RUN  = 64
) (
    input  logic             clock32,
    input  logic             reset,
    input  logic [SYM_W-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             sym_start,
    output logic             active_out
);

    if (INIT_COM < 1 || INIT_COM > 15) begin : g_bad_init_com
        $error("INIT_COM out of range 1..15");
    end
    if (MAX_RUN < 1 || MAX_RUN > 255) begin : g_bad_max_run
        $error("MAX_RUN out of range 1..255");
    end

    tx_state_e        state_q, state_d;
    logic [3:0]       com_cnt_q, com_cnt_d;
    logic [SYM_W-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             active_q, active_d;
    logic [SYM_W-1:0] load_sym;
    logic             boundary;
    logic             force_com;
`ifdef SKIP_INSERT_EN
    logic [7:0]       run_cnt_q, run_cnt_d;
`endif

    paralelo_serial_tx_shift8 #(
        .RST_SYM     (COM_SYM)
    ) u_shift8 (
        .clk_i       (clock32),
        .rst_i       (reset),
        .load_sym_i  (load_sym),
        .msb_o       (data_out),
        .sym_start_o (sym_start),
        .boundary_o  (boundary)
    );

    assign ready_out  = (state_q == ST_RUN) && !hold_valid_q;
    assign active_out = active_q;

`ifdef SKIP_INSERT_EN
    assign force_com = (run_cnt_q == 8'(MAX_RUN));
`else
    assign force_com = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        com_cnt_d    = com_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        active_d     = active_q;
        load_sym     = COM_SYM;
`ifdef SKIP_INSERT_EN
        run_cnt_d    = run_cnt_q;
`endif
        // Accept never coincides with a hold-to-shifter load: ready is low while hold is full.
        if (valid_in && ready_out) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end
        if (boundary) begin
            if (state_q == ST_INIT) begin
                com_cnt_d = com_cnt_q + 4'd1;
                active_d  = 1'b0;
`ifdef SKIP_INSERT_EN
                run_cnt_d = '0;
`endif
                if (com_cnt_q == 4'(INIT_COM - 1)) begin
                    state_d = ST_RUN;
                end
            end else if (hold_valid_q && !force_com) begin
                load_sym     = hold_q;
                hold_valid_d = 1'b0;
                active_d     = 1'b1;
`ifdef SKIP_INSERT_EN
                run_cnt_d    = run_cnt_q + 8'd1;
`endif
            end else begin
                active_d = 1'b0;
`ifdef SKIP_INSERT_EN
                run_cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clock32 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            com_cnt_q    <= '0;
            hold_valid_q <= 1'b0;
            active_q     <= 1'b0;
`ifdef SKIP_INSERT_EN
            run_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            com_cnt_q    <= com_cnt_d;
            hold_valid_q <= hold_valid_d;
            active_q     <= active_d;
`ifdef SKIP_INSERT_EN
            run_cnt_q    <= run_cnt_d;
`endif
        end
    end

    // Byte payload carries no reset; hold_valid_q qualifies it.
    always_ff @(posedge clock32) begin
        hold_q <= hold_d;
    end

endmodule
